// File: rtl/mips_exec_controller.sv
// Execution sequencer for the five-stage MIPS pipeline: run/step/stop/clear control,
// HALT drain, and a saturating count of enabled cycles for the debug port.
module mips_exec_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 ClockIn,
  input  logic                 Reset,
  input  logic                 CmdRun,
  input  logic                 CmdStep,
  input  logic                 CmdStop,
  input  logic                 CmdClear,
  input  logic                 HaltDetected,
  output logic                 PipeEnable,
  output logic                 FetchBlock,
  output logic                 PipeFlush,
  output logic                 Done,
  output logic [2:0]           State,
  output logic [CNT_WIDTH-1:0] CycleCount
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4,
    FLUSH  = 3'd5
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t               state_q, state_d;
  logic [3:0]           drain_q, drain_d;
  logic                 done_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (CmdClear)     state_d = FLUSH;
        else if (CmdRun)  state_d = RUN;
        else if (CmdStep) state_d = STEP;
      end
      RUN: begin
        // HALT outranks a simultaneous stop so in-flight instructions still retire
        if (HaltDetected) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (CmdStop) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (HaltDetected) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q <= 4'd1) state_d = HALTED;
      end
      HALTED: begin
        if (CmdClear) state_d = FLUSH;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      drain_q <= 4'd0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= (state_d == HALTED) && (state_q != HALTED);
      if (state_q == FLUSH)  cnt_q <= '0;
      else if (PipeEnable)   cnt_q <= sat_inc(cnt_q);
    end
  end

  always_comb begin
    PipeEnable = (state_q == RUN) || (state_q == STEP) || (state_q == DRAIN);
    FetchBlock = (state_q == DRAIN);
    PipeFlush  = (state_q == FLUSH);
  end

  assign Done       = done_q;
  assign State      = state_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_mips_exec_controller.sv
// Bench for mips_exec_controller: directed vector table, hand-written multi-cycle
// sequences, and random commands checked against a mode-flag reference model.
module tb_mips_exec_controller;

  localparam int D    = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, step = 1'b0, stop = 1'b0, clr = 1'b0, halt = 1'b0;
  logic          pipe_enable, fetch_block, pipe_flush, done;
  logic [2:0]    state;
  logic [CW-1:0] cycle_count;

  int errors = 0;
  int checks = 0;

  // Reference model: independent mode flags plus remaining drain cycles
  bit m_run, m_step, m_halted, m_flush, m_done;
  int m_drain, m_cnt;

  mips_exec_controller #(.DRAIN_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .ClockIn(clk), .Reset(rst_n), .CmdRun(run), .CmdStep(step), .CmdStop(stop),
    .CmdClear(clr), .HaltDetected(halt), .PipeEnable(pipe_enable),
    .FetchBlock(fetch_block), .PipeFlush(pipe_flush), .Done(done),
    .State(state), .CycleCount(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, p, c, h;
    logic [2:0] st;
    logic       dn;
    int         cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, s, p, c, h, input logic [2:0] st, input logic dn, input int cnt);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.c = c; v.h = h; v.st = st; v.dn = dn; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  function automatic logic [63:0] spec_pack(input logic [2:0] st, input logic dn, input int cnt);
    logic pe, fb, pf;
    logic [CW-1:0] c;
    pe = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    fb = (st == 3'd3);
    pf = (st == 3'd5);
    c  = CW'(cnt);
    return {{(64-7-CW){1'b0}}, st, pe, fb, pf, dn, c};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {{(64-7-CW){1'b0}}, state, pipe_enable, fetch_block, pipe_flush, done, cycle_count};
  endfunction

  function automatic logic [2:0] m_state();
    if (m_flush)     return 3'd5;
    if (m_halted)    return 3'd4;
    if (m_drain > 0) return 3'd3;
    if (m_step)      return 3'd2;
    if (m_run)       return 3'd1;
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_step = 0; m_halted = 0; m_flush = 0; m_done = 0;
    m_drain = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit en;
    en = m_run || m_step || (m_drain > 0);
    if (m_flush) m_cnt = 0;
    else if (en && m_cnt < CMAX) m_cnt++;
    m_done = 0;
    if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin m_halted = 1; m_done = 1; end
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_halted) begin
      if (clr) begin m_halted = 0; m_flush = 1; end
    end else if (m_step) begin
      m_step = 0;
      if (halt) m_drain = D;
    end else if (m_run) begin
      if (halt) begin m_run = 0; m_drain = D; end
      else if (stop) m_run = 0;
    end else begin
      if (clr) m_flush = 1;
      else if (run) m_run = 1;
      else if (step) m_step = 1;
    end
  endtask

  // One clock: inputs held across the rising edge, outputs sampled on the falling edge
  task automatic drive(input logic r, s, p, c, h);
    run = r; step = s; stop = p; clr = c; halt = h;
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    run = 0; step = 0; stop = 0; clr = 0; halt = 0;
    check("model", dut_vec(), spec_pack(m_state(), m_done, m_cnt));
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset", dut_vec(), spec_pack(3'd0, 1'b0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fbn;
    int pen;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", dut_vec(), spec_pack(3'd0, 1'b0, 0));
    rst_n = 1'b1;

    // r s p c h   state done count
    add(1,0,0,0,0, 3'd1, 0, 0);
    add(0,0,0,0,0, 3'd1, 0, 1);
    add(0,0,0,0,0, 3'd1, 0, 2);
    add(0,0,1,0,1, 3'd3, 0, 3);
    add(1,0,0,0,0, 3'd3, 0, 4);
    add(0,0,0,0,1, 3'd3, 0, 5);
    add(0,0,0,0,0, 3'd3, 0, 6);
    add(0,0,0,0,0, 3'd4, 1, 7);
    add(1,0,0,0,0, 3'd4, 0, 7);
    add(0,1,0,0,0, 3'd4, 0, 7);
    add(0,0,0,1,0, 3'd5, 0, 7);
    add(0,0,0,0,0, 3'd0, 0, 0);
    add(0,1,0,0,0, 3'd2, 0, 0);
    add(0,1,0,0,0, 3'd0, 0, 1);
    add(0,1,0,0,0, 3'd2, 0, 1);
    add(0,0,1,0,0, 3'd0, 0, 2);
    add(1,1,0,1,0, 3'd5, 0, 2);
    add(1,0,0,0,0, 3'd0, 0, 0);
    add(0,1,0,0,1, 3'd2, 0, 0);
    add(0,0,0,0,1, 3'd3, 0, 1);
    add(0,0,0,0,0, 3'd3, 0, 2);
    add(0,0,0,0,0, 3'd3, 0, 3);
    add(0,0,0,0,0, 3'd3, 0, 4);
    add(0,0,0,0,0, 3'd4, 1, 5);
    add(0,0,0,1,0, 3'd5, 0, 5);
    add(0,0,0,0,0, 3'd0, 0, 0);
    add(0,0,1,0,0, 3'd0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].h);
      check($sformatf("vec%0d", i), dut_vec(), spec_pack(tbl[i].st, tbl[i].dn, tbl[i].cnt));
    end

    // Run for ten cycles then stop
    async_reset();
    pen = 0;
    drive(0,0,0,0,0);
    drive(1,0,0,0,0); pen += int'(pipe_enable);
    repeat (9) begin drive(0,0,0,0,0); pen += int'(pipe_enable); end
    drive(0,0,1,0,0); pen += int'(pipe_enable);
    check("run_stop_pe_cycles", 64'(pen), 64'd10);
    check("run_stop_final", dut_vec(), spec_pack(3'd0, 1'b0, 10));

    // Three isolated steps
    drive(0,0,0,1,0);
    drive(0,0,0,0,0);
    for (int k = 0; k < 3; k++) begin
      drive(0,1,0,0,0);
      check("step_pulse", dut_vec(), spec_pack(3'd2, 1'b0, k));
      drive(0,0,0,0,0);
      check("step_gap", dut_vec(), spec_pack(3'd0, 1'b0, k + 1));
      drive(0,0,0,0,0);
    end
    check("step_total", 64'(cycle_count), 64'd3);

    // Drain to HALTED at count 20, then clear and resume
    drive(0,0,0,1,0);
    drive(0,0,0,0,0);
    drive(1,0,0,0,0);
    repeat (15) drive(0,0,0,0,0);
    check("pre_halt", dut_vec(), spec_pack(3'd1, 1'b0, 15));
    fbn = 0;
    drive(0,0,0,0,1); fbn += int'(fetch_block);
    repeat (3) begin drive(0,0,0,0,0); fbn += int'(fetch_block); end
    check("drain_len", 64'(fbn), 64'd4);
    drive(0,0,0,0,0);
    check("halted_done", dut_vec(), spec_pack(3'd4, 1'b1, 20));
    drive(1,0,0,0,0);
    check("halted_run_ignored", dut_vec(), spec_pack(3'd4, 1'b0, 20));
    drive(0,0,0,1,0);
    check("flush", dut_vec(), spec_pack(3'd5, 1'b0, 20));
    drive(0,0,0,0,0);
    check("after_flush", dut_vec(), spec_pack(3'd0, 1'b0, 0));
    drive(1,0,0,0,0);
    check("resume", dut_vec(), spec_pack(3'd1, 1'b0, 0));
    drive(0,0,1,0,0);

    // Asynchronous reset in the second drain cycle
    drive(0,0,0,1,0);
    drive(0,0,0,0,0);
    drive(1,0,0,0,0);
    drive(0,0,0,0,1);
    drive(0,0,0,0,0);
    check("drain_cycle2", dut_vec(), spec_pack(3'd3, 1'b0, 2));
    async_reset();
    drive(1,0,0,0,0);
    check("run_after_reset", dut_vec(), spec_pack(3'd1, 1'b0, 0));

    // Counter saturation
    repeat (CMAX + 5) drive(0,0,0,0,0);
    check("saturate", dut_vec(), spec_pack(3'd1, 1'b0, CMAX));
    drive(0,0,1,0,0);
    check("saturate_stop", dut_vec(), spec_pack(3'd0, 1'b0, CMAX));

    // Random commands against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 11) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
